// File: rtl/fpu_result_queue_pkg.sv
// Shared types for the fp16 add/sub result queue: operand/result formats,
// condition codes, status flags and the stored queue entry.
package fpu_result_queue_pkg;

    localparam int unsigned FP16_W = 16;
    localparam int unsigned CC_W   = 4;
    localparam int unsigned FLAG_W = 5;

    typedef logic [FP16_W-1:0] fp16_t;

    // Bit order {Z,C,N,V}
    typedef logic [CC_W-1:0] condCode_t;

    // Bit order {NV,DZ,OF,UF,NX}
    typedef logic [FLAG_W-1:0] opStatusFlag_t;

    typedef enum logic [1:0] {
        FPU_NOP = 2'd0,
        FPU_ADD = 2'd1,
        FPU_SUB = 2'd2
    } fpuOp_t;

    typedef struct packed {
        fpuOp_t        op;
        fp16_t         result;
        condCode_t     cc;
        opStatusFlag_t flags;
    } fpuResult_t;

    localparam fpuResult_t RESULT_NONE = '{
        op:     FPU_NOP,
        result: '0,
        cc:     '0,
        flags:  '0
    };

    // A clear and a load in the same cycle leave exactly the loaded flags.
    function automatic opStatusFlag_t merge_flags(
        input opStatusFlag_t cur,
        input logic          clr,
        input logic          load,
        input opStatusFlag_t add
    );
        opStatusFlag_t base;
        opStatusFlag_t inc;
        base = clr ? '0 : cur;
        inc  = load ? add : '0;
        return base | inc;
    endfunction

endpackage

// File: rtl/fpu_sticky_flags.sv
// Architectural sticky exception flags and last accepted condition code.
module fpu_sticky_flags
    import fpu_result_queue_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          sticky_clr,
    input  opStatusFlag_t in_flags,
    input  condCode_t     in_cc,
    output opStatusFlag_t sticky_flags,
    output condCode_t     last_cc
);

    always_ff @(posedge clock) begin
        if (reset) begin
            sticky_flags <= '0;
            last_cc      <= '0;
        end else begin
            sticky_flags <= merge_flags(sticky_flags, sticky_clr, push, in_flags);
            if (push) begin
                last_cc <= in_cc;
            end
        end
    end

endmodule

// File: rtl/fpu_result_queue.sv
// In-order result FIFO between the fp16 add/sub unit and writeback, with
// sticky exception flags and last condition code for status logic.
module fpu_result_queue
    import fpu_result_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  fp16_t            in_result,
    input  condCode_t        in_cc,
    input  opStatusFlag_t    in_flags,
    input  fpuOp_t           in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output fp16_t            out_result,
    output condCode_t        out_cc,
    output opStatusFlag_t    out_flags,
    output fpuOp_t           out_op,
    output opStatusFlag_t    sticky_flags,
    input  logic             sticky_clr,
    output condCode_t        last_cc,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fpuResult_t       mem [DEPTH];
    fpuResult_t       head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Occupancy is tracked only by count; pointer equality is ambiguous.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{op: in_op, result: in_result, cc: in_cc, flags: in_flags};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Stale storage is never exposed: an empty queue presents all-zero data.
    always_comb begin
        head = RESULT_NONE;
        if (!empty) begin
            head = mem[rd_ptr];
        end
    end

    assign out_result = head.result;
    assign out_cc     = head.cc;
    assign out_flags  = head.flags;
    assign out_op     = head.op;

    fpu_sticky_flags u_sticky (
        .clock        (clock),
        .reset        (reset),
        .push         (push),
        .sticky_clr   (sticky_clr),
        .in_flags     (in_flags),
        .in_cc        (in_cc),
        .sticky_flags (sticky_flags),
        .last_cc      (last_cc)
    );

endmodule

// File: tb/tb_fpu_result_queue.sv
// Directed table-driven bench for fpu_result_queue (DEPTH=4).
module tb_fpu_result_queue;
    import fpu_result_queue_pkg::*;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    fp16_t         in_result;
    condCode_t     in_cc;
    opStatusFlag_t in_flags;
    fpuOp_t        in_op;
    logic          out_valid;
    logic          out_ready;
    fp16_t         out_result;
    condCode_t     out_cc;
    opStatusFlag_t out_flags;
    fpuOp_t        out_op;
    opStatusFlag_t sticky_flags;
    logic          sticky_clr;
    condCode_t     last_cc;
    logic [2:0]    count;

    int n_vec;
    int n_chk;
    int n_mis;

    fpu_result_queue #(.DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_cc        (in_cc),
        .in_flags     (in_flags),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_cc       (out_cc),
        .out_flags    (out_flags),
        .out_op       (out_op),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .last_cc      (last_cc),
        .count        (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        clr;
        logic [15:0] res;
        logic [3:0]  cc;
        logic [4:0]  fl;
        logic [1:0]  op;
        logic        pre;
        logic [2:0]  cnt;
        logic [15:0] hres;
        logic [3:0]  hcc;
        logic [4:0]  hfl;
        logic [1:0]  hop;
        logic [4:0]  stk;
        logic [3:0]  lcc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic iv, input logic ordy, input logic clr,
        input logic [15:0] res, input logic [3:0] cc, input logic [4:0] fl, input logic [1:0] op,
        input logic pre, input logic [2:0] cnt,
        input logic [15:0] hres, input logic [3:0] hcc, input logic [4:0] hfl, input logic [1:0] hop,
        input logic [4:0] stk, input logic [3:0] lcc
    );
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.clr = clr;
        v.res = res; v.cc = cc; v.fl = fl; v.op = op;
        v.pre = pre; v.cnt = cnt;
        v.hres = hres; v.hcc = hcc; v.hfl = hfl; v.hop = hop;
        v.stk = stk; v.lcc = lcc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        in_result  = '0;
        in_cc      = '0;
        in_flags   = '0;
        in_op      = FPU_NOP;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " count"},        32'(count),        32'h0);
        check({tag, " out_valid"},    32'(out_valid),    32'h0);
        check({tag, " in_ready"},     32'(in_ready),     32'h1);
        check({tag, " out_result"},   32'(out_result),   32'h0);
        check({tag, " out_cc"},       32'(out_cc),       32'h0);
        check({tag, " out_flags"},    32'(out_flags),    32'h0);
        check({tag, " out_op"},       32'(out_op),       32'h0);
        check({tag, " sticky_flags"}, 32'(sticky_flags), 32'h0);
        check({tag, " last_cc"},      32'(last_cc),      32'h0);
    endtask

    task automatic apply(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clock);
        in_valid   = v.iv;
        out_ready  = v.ordy;
        sticky_clr = v.clr;
        in_result  = v.res;
        in_cc      = v.cc;
        in_flags   = v.fl;
        in_op      = fpuOp_t'(v.op);
        #1;
        check({tag, " pre-edge in_ready"}, 32'(in_ready), 32'(v.pre));
        @(posedge clock);
        #1;
        n_vec++;
        check({tag, " count"},        32'(count),        32'(v.cnt));
        check({tag, " out_valid"},    32'(out_valid),    32'(v.cnt != 3'd0));
        check({tag, " in_ready"},     32'(in_ready),     32'(v.cnt != 3'd4));
        check({tag, " out_result"},   32'(out_result),   32'(v.hres));
        check({tag, " out_cc"},       32'(out_cc),       32'(v.hcc));
        check({tag, " out_flags"},    32'(out_flags),    32'(v.hfl));
        check({tag, " out_op"},       32'(out_op),       32'(v.hop));
        check({tag, " sticky_flags"}, 32'(sticky_flags), 32'(v.stk));
        check({tag, " last_cc"},      32'(last_cc),      32'(v.lcc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_chk = 0;
        n_mis = 0;

        // iv ordy clr  res  cc  flags op | pre cnt  head res/cc/flags/op  sticky last_cc
        // In-order fill and drain
        vecs.push_back(mk(1,0,0,16'h3C00,4'h0,5'h00,2'd1, 1,3'd1,16'h3C00,4'h0,5'h00,2'd1,5'h00,4'h0));
        vecs.push_back(mk(1,0,0,16'h4000,4'h0,5'h00,2'd2, 1,3'd2,16'h3C00,4'h0,5'h00,2'd1,5'h00,4'h0));
        vecs.push_back(mk(1,0,0,16'hC200,4'h2,5'h01,2'd1, 1,3'd3,16'h3C00,4'h0,5'h00,2'd1,5'h01,4'h2));
        vecs.push_back(mk(0,1,0,16'h0000,4'h0,5'h00,2'd0, 1,3'd2,16'h4000,4'h0,5'h00,2'd2,5'h01,4'h2));
        vecs.push_back(mk(0,1,0,16'h0000,4'h0,5'h00,2'd0, 1,3'd1,16'hC200,4'h2,5'h01,2'd1,5'h01,4'h2));
        vecs.push_back(mk(0,1,0,16'h0000,4'h0,5'h00,2'd0, 1,3'd0,16'h0000,4'h0,5'h00,2'd0,5'h01,4'h2));
        vecs.push_back(mk(0,1,0,16'h0000,4'h0,5'h00,2'd0, 1,3'd0,16'h0000,4'h0,5'h00,2'd0,5'h01,4'h2));
        // Overfill: pushes 5,6 and 7 are refused, 7 even with a pop
        vecs.push_back(mk(1,0,0,16'h0001,4'h0,5'h00,2'd1, 1,3'd1,16'h0001,4'h0,5'h00,2'd1,5'h01,4'h0));
        vecs.push_back(mk(1,0,0,16'h0002,4'h0,5'h00,2'd1, 1,3'd2,16'h0001,4'h0,5'h00,2'd1,5'h01,4'h0));
        vecs.push_back(mk(1,0,0,16'h0003,4'h0,5'h00,2'd1, 1,3'd3,16'h0001,4'h0,5'h00,2'd1,5'h01,4'h0));
        vecs.push_back(mk(1,0,0,16'h0004,4'h0,5'h00,2'd1, 1,3'd4,16'h0001,4'h0,5'h00,2'd1,5'h01,4'h0));
        vecs.push_back(mk(1,0,0,16'h0005,4'hF,5'h1F,2'd2, 0,3'd4,16'h0001,4'h0,5'h00,2'd1,5'h01,4'h0));
        vecs.push_back(mk(1,0,0,16'h0006,4'hF,5'h1F,2'd2, 0,3'd4,16'h0001,4'h0,5'h00,2'd1,5'h01,4'h0));
        vecs.push_back(mk(1,1,0,16'h0007,4'hF,5'h1F,2'd2, 0,3'd3,16'h0002,4'h0,5'h00,2'd1,5'h01,4'h0));
        vecs.push_back(mk(0,1,0,16'h0000,4'h0,5'h00,2'd0, 1,3'd2,16'h0003,4'h0,5'h00,2'd1,5'h01,4'h0));
        // Push+pop at count 2 with write pointer wrapping
        vecs.push_back(mk(1,1,0,16'h7C00,4'h1,5'h05,2'd2, 1,3'd2,16'h0004,4'h0,5'h00,2'd1,5'h05,4'h1));
        vecs.push_back(mk(0,1,0,16'h0000,4'h0,5'h00,2'd0, 1,3'd1,16'h7C00,4'h1,5'h05,2'd2,5'h05,4'h1));
        vecs.push_back(mk(0,1,0,16'h0000,4'h0,5'h00,2'd0, 1,3'd0,16'h0000,4'h0,5'h00,2'd0,5'h05,4'h1));
        // Sticky clear with and without a concurrent push
        vecs.push_back(mk(1,0,1,16'h3800,4'h8,5'h10,2'd1, 1,3'd1,16'h3800,4'h8,5'h10,2'd1,5'h10,4'h8));
        vecs.push_back(mk(1,0,0,16'h3400,4'h4,5'h02,2'd2, 1,3'd2,16'h3800,4'h8,5'h10,2'd1,5'h12,4'h4));
        vecs.push_back(mk(0,0,1,16'h0000,4'h0,5'h00,2'd0, 1,3'd2,16'h3800,4'h8,5'h10,2'd1,5'h00,4'h4));
        vecs.push_back(mk(1,0,0,16'h4400,4'hC,5'h08,2'd1, 1,3'd3,16'h3800,4'h8,5'h10,2'd1,5'h08,4'hC));
        // After mid-operation reset
        vecs.push_back(mk(1,0,0,16'h5000,4'h3,5'h00,2'd2, 1,3'd1,16'h5000,4'h3,5'h00,2'd2,5'h00,4'h3));
        vecs.push_back(mk(0,1,0,16'h0000,4'h0,5'h00,2'd0, 1,3'd0,16'h0000,4'h0,5'h00,2'd0,5'h00,4'h3));

        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_vec++;
        check_reset_state("idle");

        for (int i = 0; i < 22; i++) begin
            apply(i, vecs[i]);
        end

        // One-cycle reset with 3 entries held and a competing push
        @(negedge clock);
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_result  = 16'h6000;
        in_cc      = 4'hF;
        in_flags   = 5'h1F;
        in_op      = FPU_SUB;
        sticky_clr = 1'b0;
        out_ready  = 1'b0;
        @(posedge clock);
        #1;
        n_vec++;
        check_reset_state("midreset");
        @(negedge clock);
        reset = 1'b0;
        drive_idle();

        for (int i = 22; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        @(negedge clock);
        drive_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
